// File: rtl/mdu_host_initiator_if.sv
// Bus bundle between the MDU host initiator and its command source, the MDU host port and the result sink.
// Every channel is val/rdy: a beat transfers on a clk edge with val && rdy, and msg is held while val=1 and rdy=0.
interface mdu_host_initiator_if;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [2:0]  cmd_func;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;

    logic        host_mdureq_val;
    logic        host_mdureq_rdy;
    logic [69:0] host_mdureq_msg;

    logic        host_mduresp_val;
    logic        host_mduresp_rdy;
    logic [34:0] host_mduresp_msg;

    logic        result_val;
    logic        result_rdy;
    logic [31:0] result_msg;

    modport master (
        input  cmd_val, cmd_func, cmd_a, cmd_b,
        output cmd_rdy,
        output host_mdureq_val, host_mdureq_msg,
        input  host_mdureq_rdy,
        input  host_mduresp_val, host_mduresp_msg,
        output host_mduresp_rdy,
        output result_val, result_msg,
        input  result_rdy
    );

    modport slave (
        output cmd_val, cmd_func, cmd_a, cmd_b,
        input  cmd_rdy,
        input  host_mdureq_val, host_mdureq_msg,
        output host_mdureq_rdy,
        output host_mduresp_val, host_mduresp_msg,
        input  host_mduresp_rdy,
        input  result_val, result_msg,
        output result_rdy
    );
endinterface

// File: rtl/mdu_host_initiator.sv
// Host-side initiator for the MDU host port: tags commands with a 3-bit opaque ID, limits
// requests in flight with a credit count, and reorders responses back into command order.
module mdu_host_initiator #(
    parameter int P_MAX_OUTSTANDING = 8,
    parameter int P_EN_LEAD         = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 release_req,
    mdu_host_initiator_if.master bus,
    output logic                 mdu_host_en,
    output logic                 busy,
    output logic                 err,
    output logic [31:0]          num_issued,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [3:0] LP_MAX  = 4'(P_MAX_OUTSTANDING);
    localparam logic [1:0] LP_LEAD = 2'(P_EN_LEAD);

    state_t      r_state;
    logic [1:0]  r_lead;
    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_outstanding;
    logic [7:0]  r_rob_valid;
    logic [31:0] r_rob_data [8];
    logic        r_err;
    logic [31:0] r_num_issued;

    logic        w_active;
    logic        w_credit;
    logic        w_req_fire;
    logic        w_resp_fire;
    logic        w_res_fire;
    logic [2:0]  w_resp_tag;
    logic [2:0]  w_resp_dist;
    logic        w_resp_ok;
    logic [3:0]  w_out_next;

    assign w_active = (r_state == ST_ACTIVE);
    // Credit uses the registered count, so a pop frees a slot only from the next cycle.
    assign w_credit = (r_outstanding < LP_MAX);

    assign bus.cmd_rdy          = w_active && w_credit && bus.host_mdureq_rdy;
    assign bus.host_mdureq_val  = w_active && w_credit && bus.cmd_val;
    assign bus.host_mdureq_msg  = {bus.cmd_func, r_tail, bus.cmd_a, bus.cmd_b};
    assign bus.host_mduresp_rdy = (r_state != ST_IDLE);
    assign bus.result_val       = r_rob_valid[r_head];
    assign bus.result_msg       = r_rob_data[r_head];

    assign w_req_fire  = bus.host_mdureq_val && bus.host_mdureq_rdy;
    assign w_resp_fire = bus.host_mduresp_val && bus.host_mduresp_rdy;
    assign w_res_fire  = bus.result_val && bus.result_rdy;

    // A tag is in flight when its distance from head is below the outstanding count.
    assign w_resp_tag  = bus.host_mduresp_msg[34:32];
    assign w_resp_dist = w_resp_tag - r_head;
    assign w_resp_ok   = ({1'b0, w_resp_dist} < r_outstanding) && !r_rob_valid[w_resp_tag];

    always_comb begin
        w_out_next = r_outstanding;
        if (w_req_fire && !w_res_fire) begin
            w_out_next = r_outstanding + 4'd1;
        end else if (!w_req_fire && w_res_fire) begin
            w_out_next = r_outstanding - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_lead  <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_lead  <= LP_LEAD;
                        r_state <= (LP_LEAD == 2'd0) ? ST_ACTIVE : ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    r_lead <= r_lead - 2'd1;
                    if (r_lead <= 2'd1) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (release_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the edge that retires the last result so the port is handed back at once.
                    if (w_out_next == 4'd0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head        <= 3'd0;
            r_tail        <= 3'd0;
            r_outstanding <= 4'd0;
            r_rob_valid   <= 8'd0;
            r_err         <= 1'b0;
            r_num_issued  <= 32'd0;
            for (int i = 0; i < 8; i++) begin
                r_rob_data[i] <= 32'd0;
            end
        end else begin
            r_outstanding <= w_out_next;
            if (w_req_fire) begin
                r_tail       <= r_tail + 3'd1;
                r_num_issued <= r_num_issued + 32'd1;
            end
            if (w_res_fire) begin
                r_rob_valid[r_head] <= 1'b0;
                r_head              <= r_head + 3'd1;
            end
            // The popped slot is valid and an accepted slot is not, so the two never collide.
            if (w_resp_fire) begin
                if (w_resp_ok) begin
                    r_rob_data[w_resp_tag]  <= bus.host_mduresp_msg[31:0];
                    r_rob_valid[w_resp_tag] <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign mdu_host_en = (r_state != ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign num_issued  = r_num_issued;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_mdu_host_initiator.sv
// Directed bench for mdu_host_initiator: bring-up, ordering, credit limit, bad tags, drain and reset.
module tb_mdu_host_initiator;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        release_req;
    logic        mdu_host_en;
    logic        busy;
    logic        err;
    logic [31:0] num_issued;
    logic [1:0]  state_dbg;

    int n_checks;
    int n_errors;

    mdu_host_initiator_if bus ();

    mdu_host_initiator #(
        .P_MAX_OUTSTANDING(8),
        .P_EN_LEAD        (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .release_req(release_req),
        .bus        (bus),
        .mdu_host_en(mdu_host_en),
        .busy       (busy),
        .err        (err),
        .num_issued (num_issued),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        start                = 1'b0;
        release_req          = 1'b0;
        bus.cmd_val          = 1'b0;
        bus.cmd_func         = 3'd0;
        bus.cmd_a            = 32'd0;
        bus.cmd_b            = 32'd0;
        bus.host_mdureq_rdy  = 1'b1;
        bus.host_mduresp_val = 1'b0;
        bus.host_mduresp_msg = 35'd0;
        bus.result_rdy       = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        settle();
        chk({tag, "_state"}, 70'(state_dbg), 70'd0);
        chk({tag, "_en"}, 70'(mdu_host_en), 70'd0);
        chk({tag, "_busy"}, 70'(busy), 70'd0);
        chk({tag, "_err"}, 70'(err), 70'd0);
        chk({tag, "_num"}, 70'(num_issued), 70'd0);
        chk({tag, "_res_val"}, 70'(bus.result_val), 70'd0);
        chk({tag, "_res_msg"}, 70'(bus.result_msg), 70'd0);
        chk({tag, "_cmd_rdy"}, 70'(bus.cmd_rdy), 70'd0);
        chk({tag, "_resp_rdy"}, 70'(bus.host_mduresp_rdy), 70'd0);
    endtask

    task automatic bring_up();
        drive_idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        settle();
        chk("up_state", 70'(state_dbg), 70'd2);
    endtask

    task automatic issue(input logic [2:0] func, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] exp_tag);
        bus.cmd_val  = 1'b1;
        bus.cmd_func = func;
        bus.cmd_a    = a;
        bus.cmd_b    = b;
        settle();
        chk("issue_val", 70'(bus.host_mdureq_val), 70'd1);
        chk("issue_msg", bus.host_mdureq_msg, {func, exp_tag, a, b});
        tick();
        bus.cmd_val = 1'b0;
    endtask

    task automatic respond(input logic [2:0] tag, input logic [31:0] res);
        bus.host_mduresp_val = 1'b1;
        bus.host_mduresp_msg = {tag, res};
        settle();
        chk("resp_rdy", 70'(bus.host_mduresp_rdy), 70'd1);
        tick();
        bus.host_mduresp_val = 1'b0;
    endtask

    task automatic pop(input logic [31:0] exp);
        settle();
        chk("pop_val", 70'(bus.result_val), 70'd1);
        chk("pop_msg", 70'(bus.result_msg), 70'(exp));
        bus.result_rdy = 1'b1;
        tick();
        bus.result_rdy = 1'b0;
    endtask

    initial begin
        int n_fired;
        n_checks = 0;
        n_errors = 0;
        drive_idle();

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        check_reset_state("rst");

        // Single mul 7*6 with one lead cycle before the request
        start = 1'b1;
        tick();
        start        = 1'b0;
        bus.cmd_val  = 1'b1;
        bus.cmd_func = 3'd0;
        bus.cmd_a    = 32'd7;
        bus.cmd_b    = 32'd6;
        settle();
        chk("lead_en", 70'(mdu_host_en), 70'd1);
        chk("lead_state", 70'(state_dbg), 70'd1);
        chk("lead_req_val", 70'(bus.host_mdureq_val), 70'd0);
        chk("lead_cmd_rdy", 70'(bus.cmd_rdy), 70'd0);
        tick();
        settle();
        chk("t1_req_val", 70'(bus.host_mdureq_val), 70'd1);
        chk("t1_cmd_rdy", 70'(bus.cmd_rdy), 70'd1);
        chk("t1_msg", bus.host_mdureq_msg, {3'd0, 3'd0, 32'd7, 32'd6});
        tick();
        bus.cmd_val = 1'b0;
        settle();
        chk("t1_num", 70'(num_issued), 70'd1);
        chk("t1_res_early", 70'(bus.result_val), 70'd0);
        respond(3'd0, 32'd42);
        pop(32'd42);
        settle();
        chk("t1_res_empty", 70'(bus.result_val), 70'd0);

        // Four divs answered out of order come back in tag order
        bring_up();
        for (int i = 0; i < 4; i++) begin
            issue(3'd4, 32'(1000 + i), 32'd10, 3'(i));
        end
        respond(3'd3, 32'd103);
        settle();
        chk("ooo_wait3", 70'(bus.result_val), 70'd0);
        respond(3'd1, 32'd101);
        settle();
        chk("ooo_wait1", 70'(bus.result_val), 70'd0);
        respond(3'd0, 32'd100);
        respond(3'd2, 32'd102);
        for (int i = 0; i < 4; i++) begin
            pop(32'(100 + i));
        end
        settle();
        chk("ooo_err", 70'(err), 70'd0);
        chk("ooo_num", 70'(num_issued), 70'd4);

        // Credit limit: ten back-to-back commands, silent responder
        bring_up();
        n_fired      = 0;
        bus.cmd_val  = 1'b1;
        bus.cmd_func = 3'd5;
        bus.cmd_a    = 32'd77;
        bus.cmd_b    = 32'd3;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.cmd_rdy) begin
                chk("full_tag", 70'(bus.host_mdureq_msg[66:64]), 70'(n_fired[2:0]));
                n_fired++;
            end
            tick();
        end
        settle();
        chk("full_count", 70'(n_fired), 70'd8);
        chk("full_cmd_rdy", 70'(bus.cmd_rdy), 70'd0);
        chk("full_req_val", 70'(bus.host_mdureq_val), 70'd0);
        respond(3'd0, 32'd55);
        settle();
        chk("full_still", 70'(bus.cmd_rdy), 70'd0);
        bus.result_rdy = 1'b1;
        settle();
        chk("full_pop_no_credit", 70'(bus.cmd_rdy), 70'd0);
        chk("full_pop_msg", 70'(bus.result_msg), 70'd55);
        tick();
        bus.result_rdy = 1'b0;
        settle();
        chk("wrap_cmd_rdy", 70'(bus.cmd_rdy), 70'd1);
        chk("wrap_tag", 70'(bus.host_mdureq_msg[66:64]), 70'd0);
        tick();
        bus.cmd_val = 1'b0;
        settle();
        chk("wrap_num", 70'(num_issued), 70'd9);

        // Stray and duplicate tags
        bring_up();
        issue(3'd0, 32'd3, 32'd4, 3'd0);
        issue(3'd1, 32'd5, 32'd6, 3'd1);
        respond(3'd5, 32'd500);
        settle();
        chk("bad_err", 70'(err), 70'd1);
        chk("bad_res_val", 70'(bus.result_val), 70'd0);
        respond(3'd0, 32'd11);
        respond(3'd0, 32'd99);
        settle();
        chk("dup_err", 70'(err), 70'd1);
        respond(3'd1, 32'd22);
        pop(32'd11);
        pop(32'd22);
        settle();
        chk("dup_err_sticky", 70'(err), 70'd1);

        // Release with two in flight drains before handing back the MDU
        bring_up();
        issue(3'd6, 32'd9, 32'd4, 3'd0);
        issue(3'd7, 32'd9, 32'd5, 3'd1);
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        bus.cmd_val = 1'b1;
        settle();
        chk("drain_state", 70'(state_dbg), 70'd3);
        chk("drain_cmd_rdy", 70'(bus.cmd_rdy), 70'd0);
        chk("drain_req_val", 70'(bus.host_mdureq_val), 70'd0);
        chk("drain_en", 70'(mdu_host_en), 70'd1);
        bus.cmd_val = 1'b0;
        respond(3'd0, 32'd1);
        respond(3'd1, 32'd4);
        pop(32'd1);
        settle();
        chk("drain_en_hold", 70'(mdu_host_en), 70'd1);
        pop(32'd4);
        settle();
        chk("drain_done_en", 70'(mdu_host_en), 70'd0);
        chk("drain_done_busy", 70'(busy), 70'd0);
        chk("drain_num", 70'(num_issued), 70'd2);

        // Reset mid-ACTIVE with three outstanding
        bring_up();
        for (int i = 0; i < 3; i++) begin
            issue(3'd1, 32'd8, 32'd8, 3'(i));
        end
        respond(3'd0, 32'd64);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset_state("mid_rst");
        bus.host_mduresp_val = 1'b1;
        bus.host_mduresp_msg = {3'd1, 32'd123};
        settle();
        chk("late_resp_rdy", 70'(bus.host_mduresp_rdy), 70'd0);
        tick();
        bus.host_mduresp_val = 1'b0;
        settle();
        chk("late_err", 70'(err), 70'd0);
        chk("late_res_val", 70'(bus.result_val), 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
